gpio_nibble_tx: RTL

- Transmit side of the 4-bit GPIO nibble link. The companion board samples GPIO[3:0] and shows the value on HEX0/LEDR.
- Accepts nibbles from local logic (switches, keys or the processor bridge) and buffers them in a small FIFO.
- Sends each nibble with a four-phase strobe/ack handshake, with setup/hold timing, ack timeout and bounded retry.
- Sits at board top level between the nibble source and the tri-state GPIO pins.

---
 rtl/gpio_link_pkg.sv | 24 ++
 rtl/gpio_tx_fifo.sv | 67 ++++++
 rtl/gpio_nibble_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_link_pkg
// Purpose  : Shared types and default timing for the 4-bit GPIO nibble link.
// Revision : 1.0  initial release
// ============================================================================
package gpio_link_pkg;

   localparam int LINK_DATA_W       = 4;
   localparam int c_def_fifo_depth  = 8;
   localparam int c_def_setup_cyc   = 5;
   localparam int c_def_timeout_cyc = 50000;
   localparam int c_def_max_retry   = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      RELEASE = 3'd3,
      HOLD    = 3'd4
   } link_state_t;

endpackage : gpio_link_pkg
`default_nettype wire

// File: rtl/gpio_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gpio_tx_fifo
// Purpose  : Synchronous FIFO with occupancy count, full and empty flags.
// Revision : 1.0  initial release
// ============================================================================
module gpio_tx_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int               c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0]    c_full = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A write while full is dropped even when a pop happens in the same cycle.
   assign o_full    = (r_count == c_full);
   assign o_empty   = (r_count == '0);
   assign w_push    = i_wr_en && !o_full;
   assign w_pop     = i_rd_en && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : gpio_tx_fifo
`default_nettype wire

// File: rtl/gpio_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module   : gpio_nibble_tx
// Purpose  : Buffered nibble transmitter with four-phase strobe/ack handshake.
// Revision : 1.0  initial release
// ============================================================================
module gpio_nibble_tx
   import gpio_link_pkg::*;
#(
   parameter int DATA_W      = LINK_DATA_W,
   parameter int FIFO_DEPTH  = c_def_fifo_depth,
   parameter int SETUP_CYC   = c_def_setup_cyc,
   parameter int TIMEOUT_CYC = c_def_timeout_cyc,
   parameter int MAX_RETRY   = c_def_max_retry
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_valid,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic [DATA_W-1:0]            gpio_data_out,
   output logic                         gpio_data_oe,
   output logic                         gpio_strobe,
   input  logic                         gpio_ack_in,
   input  logic                         err_clear,
   output logic                         busy,
   output logic                         err_timeout,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int                c_tw          = $clog2(TIMEOUT_CYC + 1);
   localparam int                c_rw          = $clog2(MAX_RETRY + 1);
   localparam logic [c_tw-1:0]   c_timeout     = c_tw'(TIMEOUT_CYC);
   localparam logic [c_tw-1:0]   c_setup_last  = c_tw'(SETUP_CYC - 1);
   localparam logic [c_rw-1:0]   c_max_retry   = c_rw'(MAX_RETRY);

   link_state_t       r_state;
   logic [c_tw-1:0]   r_timer;
   logic [c_rw-1:0]   r_retry;
   logic [DATA_W-1:0] r_data;
   logic              r_oe;
   logic              r_strobe;
   logic              r_err;
   logic              r_ack_meta;
   logic              r_ack_s;

   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic [c_tw-1:0]   w_timer_inc;
   logic              w_timer_end;
   logic              w_setup_end;
   logic [c_rw-1:0]   w_retry_inc;
   logic              w_last_try;

   gpio_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .i_wr_en   (wr_valid),
      .i_wr_data (wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_count   (fifo_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= gpio_ack_in;
         r_ack_s    <= r_ack_meta;
      end
   end

   // Timer counts clocks spent in the current phase and saturates at the timeout.
   always_comb begin
      w_timer_inc = (r_timer == c_timeout) ? r_timer : r_timer + 1'b1;
      w_timer_end = (w_timer_inc == c_timeout);
      w_setup_end = (r_timer == c_setup_last);
      w_retry_inc = r_retry + 1'b1;
      w_last_try  = (w_retry_inc >= c_max_retry);
      case (r_state)
         STROBE:  w_pop = !r_ack_s && w_timer_end && w_last_try;
         RELEASE: w_pop = r_ack_s && w_timer_end;
         HOLD:    w_pop = w_setup_end;
         default: w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_retry  <= '0;
         r_data   <= '0;
         r_oe     <= 1'b0;
         r_strobe <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // Error sets below are later in the block, so they beat err_clear.
         if (err_clear) begin
            r_err <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_strobe <= 1'b0;
               r_oe     <= 1'b0;
               if (!w_empty && !r_ack_s) begin
                  r_data  <= w_head;
                  r_oe    <= 1'b1;
                  r_timer <= '0;
                  r_retry <= '0;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               if (w_setup_end) begin
                  r_timer  <= '0;
                  r_strobe <= 1'b1;
                  r_state  <= STROBE;
               end else begin
                  r_timer <= w_timer_inc;
               end
            end
            STROBE: begin
               if (r_ack_s) begin
                  r_strobe <= 1'b0;
                  r_timer  <= '0;
                  r_state  <= RELEASE;
               end else if (w_timer_end) begin
                  r_strobe <= 1'b0;
                  r_timer  <= '0;
                  r_retry  <= w_retry_inc;
                  if (w_last_try) begin
                     r_err   <= 1'b1;
                     r_oe    <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_state <= SETUP;
                  end
               end else begin
                  r_timer <= w_timer_inc;
               end
            end
            RELEASE: begin
               if (!r_ack_s) begin
                  r_timer <= '0;
                  r_state <= HOLD;
               end else if (w_timer_end) begin
                  r_err   <= 1'b1;
                  r_oe    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_timer <= w_timer_inc;
               end
            end
            HOLD: begin
               if (w_setup_end) begin
                  r_oe    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_timer <= w_timer_inc;
               end
            end
            default: begin
               r_strobe <= 1'b0;
               r_oe     <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign wr_ready      = !w_full;
   assign gpio_data_out = r_data;
   assign gpio_data_oe  = r_oe;
   assign gpio_strobe   = r_strobe;
   assign err_timeout   = r_err;
   assign busy          = (r_state != IDLE) || !w_empty;

endmodule : gpio_nibble_tx
`default_nettype wire
